gpio_block_tx: RTL and testbench

GPIO_BLOCK_TX -- requirements
Module: gpio_block_tx

---
 rtl/gpio_block_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_gpio_block_tx.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_block_tx.sv
// gpio_block_tx: sends 256-bit blocks over a 24-bit GPIO port as sixteen
// 16-bit chunks using a strobe/ack four-phase handshake.
// Optional feature: define GPIO_TX_TIMEOUT_EN to enable the ack-wait timeout
// (TIMEOUT cycles) and the sticky err flag; without it err is tied low.
module gpio_block_tx #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] blk_data,
    input  logic         blk_valid,
    input  logic         blk_last,
    output logic         blk_ready,
    input  logic [23:0]  gpio_in,
    output logic [23:0]  gpio_out,
    output logic [23:0]  gpio_en,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   blk_cnt
);

    localparam int unsigned CHUNK_W    = 16;
    localparam int unsigned NUM_CHUNKS = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned GPIO_W     = 24;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned ACK_BIT    = 1;
    localparam int unsigned FS_BIT     = 7;
    localparam int unsigned FE_BIT     = 6;
    localparam int unsigned STB_BIT    = 0;
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [GPIO_W-1:0] GPIO_EN_VAL = 24'hFFFFFD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_DONE,
        ST_ERR
    } state_e;

    // A zero limit would make every handshake fail immediately.
    if (TIMEOUT == 0) begin : g_timeout_invalid
        $error("gpio_block_tx: TIMEOUT must be at least 1");
    end

    state_e                                state_q, state_d;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]    data_q, data_d;
    logic                                  last_q, last_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic                                  first_q, first_d;
    logic [CNT_W-1:0]                      blk_cnt_q, blk_cnt_d;
    logic                                  ack_meta_q, ack_s_q;
    logic [GPIO_W-1:0]                     gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0]                     gpio_en_q, gpio_en_d;
    logic                                  blk_ready_q, blk_ready_d;
    logic                                  busy_q, busy_d;
    logic                                  done_q, done_d;
    logic                                  sending_c;
    logic                                  gpio_in_unused;

`ifdef GPIO_TX_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
`endif

    // Only the ack pad is an input; the rest are outputs.
    assign gpio_in_unused = ^{gpio_in[GPIO_W-1:ACK_BIT+1], gpio_in[ACK_BIT-1:0]};

    // Two-flop synchronizer for the asynchronous ack pad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= gpio_in[ACK_BIT];
            ack_s_q    <= ack_meta_q;
        end
    end

    // State, datapath and registered-output update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            first_q     <= 1'b1;
            blk_cnt_q   <= '0;
            gpio_out_q  <= '0;
            gpio_en_q   <= '0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef GPIO_TX_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            blk_cnt_q   <= blk_cnt_d;
            gpio_out_q  <= gpio_out_d;
            gpio_en_q   <= gpio_en_d;
            blk_ready_q <= blk_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef GPIO_TX_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state logic; outputs are derived from the next state so the
    // registered pins line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        idx_d     = idx_q;
        first_d   = first_q;
        blk_cnt_d = blk_cnt_q;
`ifdef GPIO_TX_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (blk_valid && blk_ready_q) begin
                    data_d  = blk_data;
                    last_d  = blk_last;
                    idx_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
`ifdef GPIO_TX_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_STROBE: begin
                if (ack_s_q) begin
                    state_d = ST_RELEASE;
`ifdef GPIO_TX_TIMEOUT_EN
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
`endif
                end
            end
            ST_RELEASE: begin
                if (!ack_s_q) begin
                    // Frame-start marker only applies to the first chunk.
                    first_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        blk_cnt_d = blk_cnt_q + CNT_W'(1);
                        state_d   = last_q ? ST_DONE : ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SETUP;
                    end
`ifdef GPIO_TX_TIMEOUT_EN
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
`endif
                end
            end
            ST_DONE: begin
                blk_cnt_d = '0;
                first_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sending_c   = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                      (state_d == ST_RELEASE);
        blk_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_ERR);
        done_d      = (state_d == ST_DONE);
        gpio_en_d   = GPIO_EN_VAL;
        gpio_out_d  = '0;
        if (sending_c) begin
            // Chunk 0 is the most significant halfword, hence the inverted index.
            gpio_out_d[GPIO_W-1:8] = data_d[~idx_d];
            gpio_out_d[FS_BIT]     = first_d && (idx_d == '0);
            gpio_out_d[FE_BIT]     = last_d && (idx_d == IDX_LAST);
            gpio_out_d[STB_BIT]    = (state_d == ST_STROBE);
        end
    end

    assign gpio_out  = gpio_out_q;
    assign gpio_en   = gpio_en_q;
    assign blk_ready = blk_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign blk_cnt   = blk_cnt_q;

`ifdef GPIO_TX_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_block_tx.sv
// Testbench for gpio_block_tx: randomized frames against a chunk-level
// reference model, an ack responder, and directed reset/timeout scenarios.
module tb_gpio_block_tx;

    logic         clk;
    logic         rst_n;
    logic [255:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;
    logic [23:0]  gpio_in;
    logic [23:0]  gpio_out;
    logic [23:0]  gpio_en;
    logic         busy;
    logic         done;
    logic         err;
    logic [7:0]   blk_cnt;

    gpio_block_tx #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_en   (gpio_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .blk_cnt   (blk_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: one entry per chunk the port must present.
    typedef struct {
        logic [15:0] chunk;
        logic        fs;
        logic        fe;
        logic [7:0]  cnt;
    } chunk_t;

    chunk_t      exp_q[$];
    logic [7:0]  exp_done[$];
    logic        m_first = 1'b1;
    logic [7:0]  m_cnt   = 8'd0;

    function automatic void model_push(input logic [255:0] d, input logic last);
        chunk_t e;
        for (int i = 0; i < 16; i++) begin
            e.chunk = 16'(d >> (16 * (15 - i)));
            e.fs    = (i == 0) && m_first;
            e.fe    = (i == 15) && last;
            e.cnt   = m_cnt;
            exp_q.push_back(e);
        end
        if (last) begin
            exp_done.push_back(8'(m_cnt + 8'd1));
            m_cnt   = 8'd0;
            m_first = 1'b1;
        end else begin
            m_cnt   = 8'(m_cnt + 8'd1);
            m_first = 1'b0;
        end
    endfunction

    // Observation logs used by the directed literal checks.
    logic [15:0] seen_chunks[$];
    int          seen_fs_cnt = 0;
    int          seen_fe_cnt = 0;
    logic [7:0]  seen_max_cnt = 8'd0;
    logic        seen_first_fs = 1'b0;
    int          strobe_rises = 0;
    int          done_count = 0;

    logic        chk_en = 1'b0;
    logic        preack_chk = 1'b0;
    logic        prev_strobe = 1'b0;
    logic        prev_done = 1'b0;
    logic [17:0] prev_hi = '0;
    int          strobe_w = 0;

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chunk_t e;
        if (chk_en) begin
            check("gpio_en", 64'(gpio_en), 64'h00FFFFFD);
            check("gpio_out_zero_bits", 64'(gpio_out[5:1]), 64'd0);
            if (gpio_out[0]) check("busy_during_strobe", 64'(busy), 64'd1);
            if (blk_ready) check("busy_when_ready", 64'(busy), 64'd0);
            if (prev_strobe) check("data_hold", 64'(gpio_out[23:6]), 64'(prev_hi));
            if (gpio_out[0] && !prev_strobe) begin
                strobe_rises++;
                if (seen_chunks.size() == 0) seen_first_fs = gpio_out[7];
                seen_chunks.push_back(gpio_out[23:8]);
                if (gpio_out[7]) seen_fs_cnt++;
                if (gpio_out[6]) seen_fe_cnt++;
                if (blk_cnt > seen_max_cnt) seen_max_cnt = blk_cnt;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'(gpio_out[23:6]), 64'h3FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("chunk", 64'({gpio_out[23:8], gpio_out[7], gpio_out[6]}),
                          64'({e.chunk, e.fs, e.fe}));
                    check("blk_cnt_at_strobe", 64'(blk_cnt), 64'(e.cnt));
                end
            end
            if (!gpio_out[0] && prev_strobe && preack_chk)
                check("preack_strobe_width", 64'(strobe_w), 64'd1);
            if (prev_done) begin
                check("done_one_cycle", 64'(done), 64'd0);
                check("blk_cnt_cleared", 64'(blk_cnt), 64'd0);
            end
            if (done) begin
                done_count++;
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    check("blk_cnt_at_done", 64'(blk_cnt), 64'(exp_done.pop_front()));
                    check("done_after_last_chunk", 64'(exp_q.size()), 64'd0);
                end
            end
        end
        strobe_w    = gpio_out[0] ? strobe_w + 1 : 0;
        prev_strobe = gpio_out[0];
        prev_done   = done;
        prev_hi     = gpio_out[23:6];
    end

    // Ack responder. 0: random delay, 1: fixed 3-cycle delay,
    // 2: ack held high except one low cycle after each strobe fall, 3: silent.
    int   ack_mode = 3;
    int   rsp_dly = 3;
    logic rsp_prev_strobe = 1'b0;

    always @(negedge clk) begin
        case (ack_mode)
            2: gpio_in[1] = !(rsp_prev_strobe && !gpio_out[0]);
            3: gpio_in[1] = 1'b0;
            default: begin
                if (gpio_in[1] != gpio_out[0]) begin
                    if (rsp_dly == 0) begin
                        gpio_in[1] = gpio_out[0];
                        rsp_dly = (ack_mode == 1) ? 3 : int'($urandom_range(0, 4));
                    end else begin
                        rsp_dly--;
                    end
                end
            end
        endcase
        rsp_prev_strobe = gpio_out[0];
    end

    task automatic send_block(input logic [255:0] d, input logic last);
        logic r;
        int   n;
        blk_data  = d;
        blk_last  = last;
        blk_valid = 1'b1;
        n = 0;
        forever begin
            r = blk_ready;
            @(posedge clk);
            if (r) break;
            @(negedge clk);
            n++;
            if (n > 20000) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        if (r) model_push(d, last);
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = {8{$urandom()}};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && exp_done.size() == 0 && blk_ready)) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                check("idle_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic clear_logs();
        seen_chunks.delete();
        seen_fs_cnt  = 0;
        seen_fe_cnt  = 0;
        seen_max_cnt = 8'd0;
    endtask

    function automatic logic [255:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int base_s;
        int base_d;
        int n;
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        blk_data  = '0;
        gpio_in   = 24'($urandom()) & 24'hFFFFFD;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_gpio_out", 64'(gpio_out), 64'd0);
        check("rst_gpio_en", 64'(gpio_en), 64'd0);
        check("rst_blk_ready", 64'(blk_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(blk_ready), 64'd1);
        check("gpio_en_after_reset", 64'(gpio_en), 64'h00FFFFFD);
        chk_en = 1'b1;

        // Single block, 3-cycle ack delay.
        ack_mode = 1;
        clear_logs();
        base_d = done_count;
        send_block(256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF, 1'b1);
        wait_idle();
        @(negedge clk);
        check("single_strobes", 64'(seen_chunks.size()), 64'd16);
        if (seen_chunks.size() == 16) begin
            check("single_chunk0", 64'(seen_chunks[0]), 64'h0123);
            check("single_chunk1", 64'(seen_chunks[1]), 64'h4567);
            check("single_chunk15", 64'(seen_chunks[15]), 64'hCDEF);
        end
        check("single_fs_count", 64'(seen_fs_cnt), 64'd1);
        check("single_fe_count", 64'(seen_fe_cnt), 64'd1);
        check("single_done_count", 64'(done_count - base_d), 64'd1);
        check("single_blk_cnt_end", 64'(blk_cnt), 64'd0);

        // Random frames with random ack delays.
        ack_mode = 0;
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 4));
            for (int b = 0; b < n; b++) send_block(rand_blk(), b == n - 1);
            wait_idle();
        end

        // Ten-block frame.
        clear_logs();
        base_d = done_count;
        for (int b = 0; b < 10; b++) send_block(rand_blk(), b == 9);
        wait_idle();
        @(negedge clk);
        check("frame10_strobes", 64'(seen_chunks.size()), 64'd160);
        check("frame10_max_cnt", 64'(seen_max_cnt), 64'd9);
        check("frame10_done_count", 64'(done_count - base_d), 64'd1);
        check("frame10_fs_count", 64'(seen_fs_cnt), 64'd1);

        // Ack already high when each strobe starts.
        ack_mode = 2;
        repeat (5) @(negedge clk);
        preack_chk = 1'b1;
        clear_logs();
        send_block(rand_blk(), 1'b1);
        wait_idle();
        preack_chk = 1'b0;
        check("preack_strobes", 64'(seen_chunks.size()), 64'd16);
        ack_mode = 0;
        repeat (10) @(negedge clk);

        // Reset in the middle of a block at chunk 7.
        ack_mode = 1;
        base_s = strobe_rises;
        base_d = done_count;
        send_block(rand_blk(), 1'b1);
        n = 0;
        while (strobe_rises < base_s + 8 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_chunk7", 64'(strobe_rises - base_s), 64'd8);
        ack_mode = 3;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("midrst_gpio_out", 64'(gpio_out), 64'd0);
        check("midrst_gpio_en", 64'(gpio_en), 64'd0);
        check("midrst_blk_ready", 64'(blk_ready), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        exp_q.delete();
        exp_done.delete();
        m_first = 1'b1;
        m_cnt   = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", 64'(blk_ready), 64'd1);
        check("midrst_blk_cnt", 64'(blk_cnt), 64'd0);
        check("midrst_no_done", 64'(done_count - base_d), 64'd0);
        chk_en   = 1'b1;
        ack_mode = 1;
        clear_logs();
        send_block(rand_blk(), 1'b1);
        wait_idle();
        check("midrst_next_fs", 64'(seen_first_fs), 64'd1);

        // Ack never arrives.
        ack_mode = 3;
        repeat (5) @(negedge clk);
        send_block(rand_blk(), 1'b1);
        n = 0;
        while (!gpio_out[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_strobe_seen", 64'(gpio_out[0]), 64'd1);
        chk_en = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("timeout_strobe_waiting", 64'(gpio_out[0]), 64'd1);
        end
        @(negedge clk);
`ifdef GPIO_TX_TIMEOUT_EN
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_strobe_low", 64'(gpio_out[0]), 64'd0);
        check("timeout_gpio_out", 64'(gpio_out), 64'd0);
        check("timeout_busy", 64'(busy), 64'd0);
`else
        check("notimeout_err", 64'(err), 64'd0);
        check("notimeout_strobe_high", 64'(gpio_out[0]), 64'd1);
`endif
        blk_data  = rand_blk();
        blk_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stalled_blk_ready", 64'(blk_ready), 64'd0);
`ifdef GPIO_TX_TIMEOUT_EN
            check("err_sticky", 64'(err), 64'd1);
            check("err_gpio_out", 64'(gpio_out), 64'd0);
`else
            check("stalled_strobe", 64'(gpio_out[0]), 64'd1);
`endif
        end
        blk_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
